// File: rtl/rk4_pkg.sv
// ============================================================================
// Module      : rk4_pkg
// Description : Shared types and constants for the RK4 datapath and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rk4_pkg;

    localparam int RK4_WIDTH    = 32;
    localparam int RK4_PIPE_LAT = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } rk4_state_t;

endpackage

`default_nettype wire

// File: rtl/rk4_iter_ctrl_rise_detect.sv
// ============================================================================
// Module      : rise_detect
// Description : Registered rising-edge detector with synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic r_din_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_din_d <= 1'b0;
        end else begin
            r_din_d <= din;
        end
    end

    assign rise = din & ~r_din_d;

endmodule

`default_nettype wire

// File: rtl/rk4_iter_ctrl.sv
// ============================================================================
// Module      : rk4_iter_ctrl
// Description : RK4 iteration sequencer and final-result capture stage.
//               Optional trajectory streaming under RK4_ITER_STREAM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rk4_iter_ctrl
    import rk4_pkg::*;
#(
    parameter int N        = RK4_WIDTH,
    parameter int PIPE_LAT = RK4_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N-1:0]        n_iteration,
    input  logic signed [N-1:0] x_o,
    input  logic signed [N-1:0] y_o,
    input  logic signed [N-1:0] x_rk4,
    input  logic signed [N-1:0] y_rk4,
    output logic                sel,
    output logic signed [N-1:0] X,
    output logic signed [N-1:0] Y,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        iter_cnt
`ifdef RK4_ITER_STREAM_EN
    ,
    output logic                step_valid,
    output logic signed [N-1:0] x_step,
    output logic signed [N-1:0] y_step
`endif
);

    localparam int              c_PW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_PW-1:0] c_PH_LAST = c_PW'(PIPE_LAT - 1);
    localparam logic [c_PW-1:0] c_PH_ONE  = c_PW'(1);
    localparam logic [N-1:0]    c_ONE     = N'(1);

    rk4_state_t          r_state;
    rk4_state_t          w_state_nxt;
    logic [c_PW-1:0]     r_phase;
    logic [N-1:0]        r_n_lat;
    logic [N-1:0]        r_iter_cnt;
    logic signed [N-1:0] r_x;
    logic signed [N-1:0] r_y;
    logic                w_start_rise;
    logic                w_last_phase;
    logic                w_final;
    logic                w_seed_zero;
    logic [N-1:0]        w_cnt_inc;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .rise  (w_start_rise)
    );

    assign w_seed_zero  = (n_iteration == '0);
    assign w_last_phase = (r_state == ST_RUN) && (r_phase == c_PH_LAST);
    assign w_cnt_inc    = r_iter_cnt + c_ONE;
    assign w_final      = w_last_phase && (w_cnt_inc == r_n_lat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = w_seed_zero ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_final) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sel  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_LOAD: busy = 1'b1;
            ST_RUN: begin
                sel  = 1'b1;
                busy = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Only the last phase of each PIPE_LAT-cycle slot carries a completed step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_n_lat    <= '0;
            r_iter_cnt <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_n_lat    <= n_iteration;
                        r_iter_cnt <= '0;
                        r_phase    <= '0;
                        if (w_seed_zero) begin
                            r_x <= x_o;
                            r_y <= y_o;
                        end
                    end
                end
                ST_LOAD: r_phase <= '0;
                ST_RUN: begin
                    if (w_last_phase) begin
                        r_phase    <= '0;
                        r_iter_cnt <= w_cnt_inc;
                        if (w_final) begin
                            r_x <= x_rk4;
                            r_y <= y_rk4;
                        end
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign X        = r_x;
    assign Y        = r_y;
    assign iter_cnt = r_iter_cnt;

`ifdef RK4_ITER_STREAM_EN
    logic signed [N-1:0] r_x_step;
    logic signed [N-1:0] r_y_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_step <= '0;
            r_y_step <= '0;
        end else if (w_last_phase) begin
            r_x_step <= x_rk4;
            r_y_step <= y_rk4;
        end
    end

    assign step_valid = w_last_phase;
    assign x_step     = r_x_step;
    assign y_step     = r_y_step;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rk4_iter_ctrl.sv
// ============================================================================
// Module      : tb_rk4_iter_ctrl
// Description : Self-checking bench for rk4_iter_ctrl (RK4_ITER_STREAM_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rk4_iter_ctrl;
    import rk4_pkg::*;

    localparam int N  = RK4_WIDTH;
    localparam int PL = RK4_PIPE_LAT;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [N-1:0]        n_iteration = '0;
    logic signed [N-1:0] x_o = '0;
    logic signed [N-1:0] y_o = '0;
    logic signed [N-1:0] x_rk4 = '0;
    logic signed [N-1:0] y_rk4 = '0;
    logic                sel;
    logic signed [N-1:0] X;
    logic signed [N-1:0] Y;
    logic                busy;
    logic                done;
    logic [N-1:0]        iter_cnt;
`ifdef RK4_ITER_STREAM_EN
    logic                step_valid;
    logic signed [N-1:0] x_step;
    logic signed [N-1:0] y_step;
`endif

    int           cmp  = 0;
    int           mism = 0;
    logic [N-1:0] exp_x = '0;
    logic [N-1:0] exp_y = '0;
    logic [N-1:0] xr [0:127];
    logic [N-1:0] yr [0:127];

    rk4_iter_ctrl #(.N(N), .PIPE_LAT(PL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .n_iteration (n_iteration),
        .x_o         (x_o),
        .y_o         (y_o),
        .x_rk4       (x_rk4),
        .y_rk4       (y_rk4),
        .sel         (sel),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .iter_cnt    (iter_cnt)
`ifdef RK4_ITER_STREAM_EN
        ,
        .step_valid  (step_valid),
        .x_step      (x_step),
        .y_step      (y_step)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Cycle k is the k-th clock period after the accepted start edge.
    // mode 0: start pulse, 1: start held high, 2: extra edge at RUN phase 2,
    // 3: reset asserted during cycle 8 (iter_cnt==1 for n>=2).
    task automatic run_case(input int n, input int mode, input logic [N-1:0] sx,
                            input logic [N-1:0] sy);
        int   last;
        int   k_end;
        int   cnt_e;
        bit   aborted;
        logic sel_e, busy_e, done_e, sv_e;

        start = 1'b0;
        @(posedge clk); #1;
        last        = (n == 0) ? 1 : 2 + PL * n;
        k_end       = last + 3;
        aborted     = 1'b0;
        n_iteration = N'(n);
        x_o         = sx;
        y_o         = sy;
        start       = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= k_end; k++) begin
            if (mode == 3 && k == 9) begin
                aborted = 1'b1;
                exp_x   = '0;
                exp_y   = '0;
            end
            if (aborted) begin
                sel_e = 1'b0; busy_e = 1'b0; done_e = 1'b0; sv_e = 1'b0; cnt_e = 0;
            end else begin
                sel_e  = (k >= 2) && (k <= 1 + PL * n);
                busy_e = (n > 0) && (k < last);
                done_e = (k == last);
                cnt_e  = (k < 2) ? 0 : (((k - 2) / PL > n) ? n : (k - 2) / PL);
                sv_e   = sel_e && (((k - 2) % PL) == PL - 1);
                if (done_e) begin
                    exp_x = (n == 0) ? sx : xr[last - 1];
                    exp_y = (n == 0) ? sy : yr[last - 1];
                end
            end
            chk("sel", N'(sel), N'(sel_e));
            chk("busy", N'(busy), N'(busy_e));
            chk("done", N'(done), N'(done_e));
            chk("iter_cnt", iter_cnt, N'(cnt_e));
            chk("X", X, exp_x);
            chk("Y", Y, exp_y);
`ifdef RK4_ITER_STREAM_EN
            chk("step_valid", N'(step_valid), N'(sv_e));
            if (!aborted && k >= 3 && ((k - 2) % PL) == 0 && (k - 2) / PL >= 1
                && (k - 2) / PL <= n) begin
                chk("x_step", x_step, xr[k - 1]);
                chk("y_step", y_step, yr[k - 1]);
            end
`endif
            xr[k]       = $urandom;
            yr[k]       = $urandom;
            x_rk4       = xr[k];
            y_rk4       = yr[k];
            n_iteration = $urandom;
            x_o         = $urandom;
            y_o         = $urandom;
            start       = (mode == 1) || (mode == 2 && k == 4);
            rst_n       = !(mode == 3 && k == 8);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", N'(sel), '0);
        chk("rst_busy", N'(busy), '0);
        chk("rst_done", N'(done), '0);
        chk("rst_iter_cnt", iter_cnt, '0);
        chk("rst_X", X, '0);
        chk("rst_Y", Y, '0);
        rst_n = 1'b1;

        run_case(3, 0, 32'h0001_0000, 32'h0002_0000);
        run_case(0, 0, 32'd5, 32'd7);
        run_case(2, 1, $urandom, $urandom);
        run_case(3, 2, $urandom, $urandom);
        run_case(3, 3, $urandom, $urandom);
        run_case(1, 0, $urandom, $urandom);
        for (int i = 0; i < 4; i++) begin
            run_case($urandom_range(1, 4), 0, $urandom, $urandom);
        end
        run_case(2, 0, $urandom, $urandom);
        run_case(0, 1, $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule

`default_nettype wire
